// File: rtl/jtag_host_pkg.sv
// Shared types and helpers for the JTAG host: op codes, FSM states, TMS preamble patterns
// and length clamping.
package jtag_host_pkg;

    localparam int unsigned MaxLen = 32;
    localparam int unsigned LenW   = 6;
    localparam int unsigned DataW  = 32;

    typedef enum logic [1:0] {
        OpReset   = 2'd0,
        OpIdle    = 2'd1,
        OpShiftIr = 2'd2,
        OpShiftDr = 2'd3
    } jtag_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StShift,
        StPost,
        StDone
    } jtag_state_e;

    // TMS values sent LSB first, one per TCK, before any shift phase.
    typedef struct packed {
        logic [LenW-1:0] pat;
        logic [LenW-1:0] len;
    } preamble_t;

    function automatic logic [LenW-1:0] clamp_len(input logic [LenW-1:0] len);
        logic [LenW-1:0] r;
        r = len;
        if (len == '0) r = LenW'(1);
        else if (len > LenW'(MaxLen)) r = LenW'(MaxLen);
        return r;
    endfunction

    function automatic preamble_t preamble(input jtag_op_e op, input logic [LenW-1:0] len);
        preamble_t p;
        case (op)
            OpReset:   p = '{pat: 6'b011111, len: 6'd6};
            OpIdle:    p = '{pat: 6'b000000, len: len};
            OpShiftIr: p = '{pat: 6'b000011, len: 6'd4};
            default:   p = '{pat: 6'b000001, len: 6'd3};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/jtag_host_if.sv
// Command/response handshake between a controller and the JTAG host.
interface jtag_host_if;
    import jtag_host_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    jtag_op_e         cmd_op;
    logic [LenW-1:0]  cmd_len;
    logic [DataW-1:0] cmd_data;
    logic             rsp_valid;
    logic [DataW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk cycles low then CLK_DIV high, with strobes marking the cycle tck
// first reads high (rise_stb) and the last cycle of each TCK period (fall_stb).
module jtag_tck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int unsigned Period = 2 * CLK_DIV;
    localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;

    localparam logic [CntW-1:0] PreRise = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] Rise    = CntW'(CLK_DIV);
    localparam logic [CntW-1:0] Last    = CntW'(Period - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_q <= '0;
            tck   <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
            if (cnt_q == PreRise) tck <= 1'b1;
            else if (cnt_q == Last) tck <= 1'b0;
        end
    end

    assign rise_stb = run && (cnt_q == Rise);
    assign fall_stb = run && (cnt_q == Last);

endmodule

// File: rtl/jtag_host.sv
// JTAG initiator: accepts RESET/IDLE/SHIFT_IR/SHIFT_DR commands, walks the target TAP from
// Run-Test/Idle and back, and returns the TDO bits captured during the shift phase.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    jtag_host_if.slave  bus,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo,
    output logic        trst_n
);

    jtag_state_e      state_q;
    jtag_op_e         op_q;
    logic [LenW-1:0]  len_q;
    logic [DataW-1:0] data_q;
    preamble_t        pre_q;
    logic [LenW-1:0]  bit_cnt_q;
    logic [DataW-1:0] cap_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [DataW-1:0] rsp_data_q;
    logic             tms_q;
    logic             tdi_q;
    logic             trst_n_q;

    logic fall_stb, rise_stb, run;

    assign run = (state_q == StPre) || (state_q == StShift) || (state_q == StPost);

    jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .tck      (tck),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    logic            accept;
    logic [LenW-1:0] acc_len;
    preamble_t       acc_pre;
    logic [LenW-1:0] bit_nxt;
    logic            pre_last;
    logic            shift_last;
    logic            pre_tms;

    assign accept     = bus.cmd_valid && cmd_ready_q;
    assign acc_len    = clamp_len(bus.cmd_len);
    assign acc_pre    = preamble(bus.cmd_op, acc_len);
    assign bit_nxt    = bit_cnt_q + LenW'(1);
    assign pre_last   = (bit_cnt_q == pre_q.len - LenW'(1));
    assign shift_last = (bit_cnt_q == len_q - LenW'(1));
    assign pre_tms    = |(pre_q.pat & (LenW'(1) << bit_nxt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpReset;
            len_q       <= '0;
            data_q      <= '0;
            pre_q       <= '0;
            bit_cnt_q   <= '0;
            cap_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_n_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    tms_q       <= 1'b0;
                    tdi_q       <= 1'b0;
                    trst_n_q    <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                    if (accept) begin
                        state_q     <= StPre;
                        op_q        <= bus.cmd_op;
                        len_q       <= acc_len;
                        data_q      <= bus.cmd_data;
                        pre_q       <= acc_pre;
                        bit_cnt_q   <= '0;
                        cap_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        tms_q       <= acc_pre.pat[0];
                        trst_n_q    <= (bus.cmd_op != OpReset);
                    end
                end
                StPre: begin
                    if (fall_stb) begin
                        if (!pre_last) begin
                            bit_cnt_q <= bit_nxt;
                            tms_q     <= pre_tms;
                        end else if (op_q[1]) begin
                            // Both shift ops have bit 1 set in their op code.
                            state_q   <= StShift;
                            bit_cnt_q <= '0;
                            tms_q     <= (len_q == LenW'(1));
                            tdi_q     <= data_q[0];
                        end else begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            cmd_ready_q <= 1'b1;
                            tms_q       <= 1'b0;
                            trst_n_q    <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    if (rise_stb) cap_q[bit_cnt_q[4:0]] <= tdo;
                    if (fall_stb) begin
                        if (shift_last) begin
                            state_q   <= StPost;
                            bit_cnt_q <= '0;
                            tms_q     <= 1'b1;
                            tdi_q     <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_nxt;
                            tms_q     <= (bit_nxt == len_q - LenW'(1));
                            tdi_q     <= data_q[bit_nxt[4:0]];
                        end
                    end
                end
                StPost: begin
                    if (fall_stb) begin
                        if (bit_cnt_q == '0) begin
                            bit_cnt_q <= LenW'(1);
                            tms_q     <= 1'b0;
                        end else begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= cap_q;
                            cmd_ready_q <= 1'b1;
                            tms_q       <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign tms           = tms_q;
    assign tdi           = tdi_q;
    assign trst_n        = trst_n_q;

endmodule

// File: doc/jtag_host.md
# jtag_host

JTAG initiator that drives TCK/TMS/TDI and samples TDO. Firmware or a bench controller issues commands over a valid/ready interface; the block walks the TAP state machine of an attached JTAG target and returns captured TDO bits. It sits beside the existing TAP target in the Tiny Tapeout top, so a single die can exercise a TAP from the host side. All TAP sequences start and end in Run-Test/Idle.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per TCK half-period. Must be ≥1.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block idle and accepting commands. Reset value 0; goes to 1 on the cycle after `rst` deasserts.
- `cmd_op` in 2: operation. 0=RESET, 1=IDLE, 2=SHIFT_IR, 3=SHIFT_DR.
- `cmd_len` in 6: bit count or TCK count. 0 clamps to 1; values above 32 clamp to 32.
- `cmd_data` in 32: TDI bits, shifted LSB first.
- `rsp_valid` out 1: one-cycle pulse when a command completes. Reset value 0.
- `rsp_data` out 32: captured TDO, right-aligned, with upper bits zero. Holds its value until the next completion. Reset value 0.
- `tck` out 1: reset value 0.
- `tms` out 1: reset value 1.
- `tdi` out 1: reset value 0.
- `tdo` in 1: from the target.
- `trst_n` out 1: reset value 0.

## Operation
- **Handshake.** A command is accepted when `cmd_valid && cmd_ready`. `cmd_ready` drops on the following cycle and stays low until `rsp_valid` pulses. `cmd_ready` reasserts in the same cycle as `rsp_valid`, so back-to-back commands are allowed.
- **Latching.** The op, the clamped length and the data are latched at acceptance. Input changes after acceptance are ignored.
- **FSM states:** `S_IDLE` → `S_PRE` (TMS preamble) → `S_SHIFT` (data bits; SHIFT ops only) → `S_POST` (TMS postamble) → `S_DONE` (1 cycle, pulses `rsp_valid`) → `S_IDLE`.
- **TMS sequences** (one value per TCK cycle):
  - RESET: preamble 1,1,1,1,1, then 0. `trst_n` is low for the whole op and high otherwise. No shift phase. `rsp_data` = 0.
  - IDLE: `len` TCK cycles with TMS=0. No TDI/TDO exchange. `rsp_data` = 0.
  - SHIFT_DR: preamble 1,0,0. Then `len` bits with TMS=0, except TMS=1 on the last bit. Postamble 1,0.
  - SHIFT_IR: preamble 1,1,0,0. Shift phase as SHIFT_DR. Postamble 1,0.
- **Bit order.** TDI bit i = `cmd_data[i]`. The TDO bit sampled during shift cycle i goes to `rsp_data[i]`.
- **Idle levels.** Outside the shift phase TDI = 0. When `S_IDLE` is entered, TMS is held at 0.
- **Reset mid-operation.** All outputs return to their reset values on the next edge and any in-flight command is dropped with no `rsp_valid`. The next command should be RESET.

## Timing
- **TCK period:** 2·`CLK_DIV` `clk` cycles. `tck` idles low.
- **Low phase.** Each TCK cycle starts with `tck` falling or held low for `CLK_DIV` cycles. `tms`/`tdi` update in the first clk cycle of the low phase.
- **High phase.** `tck` is high for the next `CLK_DIV` cycles. `tdo` is registered in the clk cycle in which `tck` goes 1, i.e. at the target's rising edge.
- **First TCK cycle.** It begins in the cycle after acceptance.
- **Latency from acceptance to `rsp_valid`**, where T = 2·`CLK_DIV` and `rsp_valid` comes one clk after the last TCK high phase ends:

  | Op | clk cycles |
  |---|---|
  | RESET | 6·T + 1 |
  | IDLE | len·T + 1 |
  | SHIFT_DR | (len+5)·T + 1 |
  | SHIFT_IR | (len+6)·T + 1 |

- **Widths.** The bit counter is 6 bits. The shift phase ends when counter == len−1, so len=32 does not wrap.

## Structure
- **Shared include `jtag_host_defs.vh`:** op codes (`JTAG_OP_RESET/IDLE/SHIFT_IR/SHIFT_DR`), FSM state encodings, max length 32.
- **Sub-module `jtag_tck_gen`:** `CLK_DIV` divider. Runs only while the FSM is outside `S_IDLE`, and produces one-cycle `fall_stb`/`rise_stb` strobes plus `tck`. `jtag_host` advances TMS/TDI on `fall_stb` and samples `tdo` on `rise_stb`.

## Test plan
The bench contains a behavioural TAP target with a 4-bit IR and a 32-bit DR loaded with 0x1234_5678 at Capture-DR.

- **RESET, `CLK_DIV`=2:** accept at cycle 0 → `tms` shows 1,1,1,1,1,0 on six rising edges; `trst_n` is low throughout; `rsp_valid` at cycle 25; the model is in Run-Test/Idle.
- **SHIFT_DR, len=32, data=0xDEAD_BEEF:** → `rsp_data`=0x1234_5678; the model's DR receives 0xDEAD_BEEF; 37 rising edges; the model ends in Run-Test/Idle.
- **SHIFT_IR, len=4, data=0x5:** → the model's IR is 0x5; `rsp_data` = the capture pattern 0x1 (bits 3:0); 10 rising edges.
- **Clamping:** len=0 → exactly 1 shift bit. len=40 → 32 bits, `rsp_data` with the full 32-bit value.
- **Back-to-back:** `cmd_valid` held high with SHIFT_DR len=8 twice → second acceptance in the same cycle as the first `rsp_valid`; no extra idle TCK cycles between commands.
- **Reset mid-operation:** `rst` pulsed for 1 cycle during bit 10 of a 32-bit SHIFT_DR → next cycle `tck`=0, `tms`=1, `tdi`=0, `trst_n`=0, `cmd_ready`=0; no `rsp_valid`; `cmd_ready`=1 one cycle after release.
